// File: rtl/vector_list_player.sv
// vector_list_player: display-list sequencer feeding the line-draw engine.
// On a start pulse it reads 32-bit words from a synchronous-read memory, starting
// at address 0. It decodes each word and issues it to the line engine:
//   [31:30] opcode  00 JUMP, 01 DRAW, 10 HALT, 11 NOP
//   [29:24] reserved, ignored
//   [23:12] X
//   [11:0]  Y
// A frame ends on a HALT word or after the last memory word has been issued.
//
// Ports:
//   clk, reset      clock; synchronous active-low reset
//   start           one-cycle pulse; starts a frame (ignored while busy)
//   mem_addr/mem_rd display-list read port; data is valid one cycle after mem_rd
//   mem_data        display-list word
//   x, y            target coordinates; hold their value between commands
//   draw, jump      one-cycle command pulses to the line engine
//   ready           line engine can accept a command
//   busy            frame in progress
//   frame_done      one-cycle end-of-frame pulse
//
// Build option: define VECTOR_LIST_LOOP_EN to restart the frame from address 0
// automatically. In that mode, only reset stops the sequencer.
module vector_list_player #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned COORD_W = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [31:0]        mem_data,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               draw,
  output logic               jump,
  input  logic               ready,
  output logic               busy,
  output logic               frame_done
);

  localparam logic [1:0] OP_JUMP = 2'b00;
  localparam logic [1:0] OP_DRAW = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [ADDR_W-1:0]    r_addr;
  logic [1:0]           r_op;
  logic [COORD_W-1:0]   r_cx;
  logic [COORD_W-1:0]   r_cy;
  logic [COORD_W-1:0]   r_x;
  logic [COORD_W-1:0]   r_y;
  logic                 r_draw;
  logic                 r_jump;
  logic                 r_mem_rd;
  logic                 r_busy;
  logic                 r_frame_done;

  logic [ADDR_W-1:0]    w_addr_nxt;
  logic [1:0]           w_op_nxt;
  logic [COORD_W-1:0]   w_cx_nxt;
  logic [COORD_W-1:0]   w_cy_nxt;
  logic [COORD_W-1:0]   w_x_nxt;
  logic [COORD_W-1:0]   w_y_nxt;
  logic                 w_draw_nxt;
  logic                 w_jump_nxt;
  logic                 w_mem_rd_nxt;
  logic                 w_busy_nxt;
  logic                 w_frame_done_nxt;

  logic                 w_issue_go;
  logic                 w_last;
  logic                 w_frame_end;
  logic                 w_restart;
  logic                 w_unused;

  assign w_unused = ^mem_data[29:24];

  // Current command completes this cycle: JUMP/DRAW need ready, HALT/NOP do not
  always_comb begin
    w_issue_go = 1'b0;
    case (r_op)
      OP_JUMP, OP_DRAW: w_issue_go = ready;
      OP_HALT, OP_NOP:  w_issue_go = 1'b1;
      default:          w_issue_go = 1'b0;
    endcase
  end

  // The last memory word ends the frame like HALT; the address never wraps
  assign w_last      = &r_addr;
  assign w_frame_end = (r_state == S_ISSUE) && w_issue_go && ((r_op == OP_HALT) || w_last);

`ifdef VECTOR_LIST_LOOP_EN
  assign w_restart = r_frame_done;
`else
  assign w_restart = 1'b0;
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_op         <= '0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_draw       <= 1'b0;
      r_jump       <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_op         <= w_op_nxt;
      r_cx         <= w_cx_nxt;
      r_cy         <= w_cy_nxt;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_draw       <= w_draw_nxt;
      r_jump       <= w_jump_nxt;
      r_mem_rd     <= w_mem_rd_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start || w_restart) w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = S_WAIT;
      S_WAIT:  w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_issue_go) w_state_nxt = w_frame_end ? S_IDLE : S_FETCH;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values for the datapath and the registered outputs
  always_comb begin
    w_addr_nxt       = r_addr;
    w_op_nxt         = r_op;
    w_cx_nxt         = r_cx;
    w_cy_nxt         = r_cy;
    w_x_nxt          = r_x;
    w_y_nxt          = r_y;
    w_draw_nxt       = 1'b0;
    w_jump_nxt       = 1'b0;
    w_frame_done_nxt = 1'b0;
    // mem_rd and busy are looked up from the state being entered, so they are
    // valid in the same cycle as that state
    w_mem_rd_nxt     = (w_state_nxt == S_FETCH);
    w_busy_nxt       = (w_state_nxt != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (start || w_restart) w_addr_nxt = '0;
      end
      S_WAIT: begin
        w_op_nxt = mem_data[31:30];
        w_cx_nxt = COORD_W'(mem_data[23:12]);
        w_cy_nxt = COORD_W'(mem_data[11:0]);
      end
      S_ISSUE: begin
        if (w_issue_go) begin
          if (r_op == OP_JUMP || r_op == OP_DRAW) begin
            w_x_nxt    = r_cx;
            w_y_nxt    = r_cy;
            w_jump_nxt = (r_op == OP_JUMP);
            w_draw_nxt = (r_op == OP_DRAW);
          end
          if (w_frame_end) begin
            w_addr_nxt       = '0;
            w_frame_done_nxt = 1'b1;
`ifdef VECTOR_LIST_LOOP_EN
            w_busy_nxt       = 1'b1;
`endif
          end else begin
            w_addr_nxt = r_addr + ADDR_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign mem_addr   = r_addr;
  assign mem_rd     = r_mem_rd;
  assign x          = r_x;
  assign y          = r_y;
  assign draw       = r_draw;
  assign jump       = r_jump;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: doc/vector_list_player.md
# vector_list_player

Display-list sequencer that sits directly upstream of the `control` line-draw engine. On a start pulse it walks a synchronous-read vector memory from address 0 and decodes each 32-bit word into a jump or draw command. It hands each command to the line engine over the existing `x`/`y`/`draw`/`jump`/`ready` handshake and signals end of frame on a HALT word or at the end of memory.

## Interface
- `ADDR_W`, 10: display-list address width; memory depth is 2^ADDR_W words.
- `COORD_W`, 12: coordinate width; fixed to 12 by the word format.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low; 0 = in reset.
- `start`  in  1  one-cycle pulse; begins a frame from address 0.
- `mem_addr`  out  ADDR_W  display-list read address.
- `mem_rd`  out  1  read strobe; data is valid on `mem_data` one cycle later.
- `mem_data`  in  32  display-list word.
- `x`  out  12  target X to the line engine.
- `y`  out  12  target Y to the line engine.
- `draw`  out  1  one-cycle pulse: draw a line to (`x`,`y`).
- `jump`  out  1  one-cycle pulse: move the beam to (`x`,`y`) blanked.
- `ready`  in  1  line engine can accept a command.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse at end of frame.

## Operation
- Word format:
  - [31:30] opcode: 00 JUMP, 01 DRAW, 10 HALT, 11 NOP.
  - [29:24] reserved, ignored.
  - [23:12] X; [11:0] Y.
- States:
  - IDLE: `busy`=0. `start`=1 → FETCH, address := 0.
  - FETCH: `mem_rd`=1 and `mem_addr`=address for exactly one cycle → WAIT.
  - WAIT: capture `mem_data` into the command register → ISSUE.
  - ISSUE, opcode JUMP/DRAW: hold until `ready`=1. On that edge, register X/Y onto `x`/`y`, set `jump` or `draw` for one cycle, increment address → FETCH.
  - ISSUE, opcode NOP: no pulse, increment address → FETCH. `ready` is ignored.
  - ISSUE, opcode HALT: pulse `frame_done`, address := 0 → IDLE. `ready` is ignored.
- End of memory: after the word at address 2^ADDR_W−1 is issued (any opcode), behave as HALT. Address never wraps mid-frame.
- `start` is ignored while `busy`=1.
- `x`/`y` hold their last issued value between commands.
- `draw` and `jump` are never high together.
- Reset active (`reset`=0):
  - state IDLE, address 0;
  - `x`=0, `y`=0, `draw`=0, `jump`=0, `mem_rd`=0, `mem_addr`=0, `busy`=0, `frame_done`=0;
  - applies mid-frame and discards any pending command.

## Timing
- All outputs are registered.
- `start` sampled at edge T. `mem_rd` is high in cycle T+1 and data is captured at the end of T+2. ISSUE is cycle T+3; with `ready`=1, the `jump`/`draw` pulse and new `x`/`y` appear in T+4.
- Minimum command period is 3 cycles (FETCH, WAIT, ISSUE). This guarantees the line engine at least 2 cycles to deassert `ready` before it is sampled again.
- `busy` rises the cycle after `start` is sampled. It falls in the same cycle `frame_done` is high.
- `mem_rd` is high only in FETCH. Memory is not read while stalled on `ready`.

## Configuration
- `VECTOR_LIST_LOOP_EN` defined:
  - after HALT or end of memory, pulse `frame_done`, then go straight to FETCH at address 0 without needing `start`;
  - `busy` stays 1 and only reset stops the sequencer.
- Not defined: return to IDLE after each frame and wait for the next `start`.

## Test plan
- Memory [0]=JUMP(50,10), [1]=DRAW(0,40), [2]=DRAW(50,50), [3]=HALT; `ready`=1; `start` at T:
  - `jump` in T+4 with x=50, y=10;
  - `draw` in T+7 (0,40) and in T+10 (50,50);
  - `frame_done` in T+13, then `busy`=0.
- Same list with `ready`=0 for 20 cycles after `start`: no pulse, `mem_rd` low after T+1, and `x`/`y` stay 0. Exactly one `jump` (50,10) follows the cycle after `ready` rises.
- [0]=NOP, [1]=NOP, [2]=DRAW(7,9), [3]=HALT: the first and only pulse is `draw` (7,9) in T+10, and `x`/`y` are unchanged during the NOPs.
- Reset asserted in the cycle after the first `jump`: all outputs 0 next cycle. A fresh `start` replays from address 0 with `jump` (50,10) again.
- ADDR_W=2 with no HALT in 4 DRAW words: four `draw` pulses, then `frame_done`. The `start` pulse given mid-frame is ignored.
- With `VECTOR_LIST_LOOP_EN`: after `frame_done`, the next cycle shows `mem_rd`=1, `mem_addr`=0, and `busy` stays 1. Without the macro, `busy` drops and no further reads occur.
